// File: rtl/share_pkg.sv
// ============================================================================
// Module      : share_pkg
// Description : Shared types and constants for the two-share masking encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package share_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int COUNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RND = 2'd1,
        OUT      = 2'd2
    } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/share_xor_reg.sv
// ============================================================================
// Module      : share_xor_reg
// Description : Registered WIDTH-bit XOR with async active-low reset,
//               synchronous clear and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module share_xor_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= a ^ b;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/share_encoder.sv
// ============================================================================
// Module      : share_encoder
// Description : Two-share Boolean masking encoder, s0 = rnd, s1 = data ^ rnd,
//               both driven from flops. Optional SHARE_CHECK_EN adds a
//               recombination checker and the chk_err port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module share_encoder
    import share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    input  logic [WIDTH-1:0]   rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_s0,
    output logic [WIDTH-1:0]   out_s1,
    output logic [COUNT_W-1:0] enc_count
`ifdef SHARE_CHECK_EN
    ,
    output logic               chk_err
`endif
);

    localparam logic [1:0] c_ST_IDLE     = 2'(IDLE);
    localparam logic [1:0] c_ST_WAIT_RND = 2'(WAIT_RND);
    localparam logic [1:0] c_ST_OUT      = 2'(OUT);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_data;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]   w_s0;
    logic [WIDTH-1:0]   w_s1;
    logic               w_in_fire;
    logic               w_rnd_fire;
    logic               w_out_fire;

    // Handshake readies come from state alone, never from the valids.
    assign in_ready   = (r_state == c_ST_IDLE);
    assign rnd_ready  = (r_state == c_ST_WAIT_RND);
    assign out_valid  = (r_state == c_ST_OUT);

    assign w_in_fire  = in_ready  & in_valid;
    assign w_rnd_fire = rnd_ready & rnd_valid;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_in_fire) begin
                        r_data  <= in_data;
                        r_state <= c_ST_WAIT_RND;
                    end
                end
                c_ST_WAIT_RND: begin
                    // Drop the plain word as soon as it has been masked.
                    if (w_rnd_fire) begin
                        r_data  <= '0;
                        r_state <= c_ST_OUT;
                    end
                end
                c_ST_OUT: begin
                    if (w_out_fire) begin
                        r_count <= r_count + COUNT_W'(1);
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    share_xor_reg #(.WIDTH(WIDTH)) u_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_out_fire),
        .load  (w_rnd_fire),
        .a     (r_data),
        .b     (rnd),
        .q     (w_s1)
    );

    share_xor_reg #(.WIDTH(WIDTH)) u_s0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_out_fire),
        .load  (w_rnd_fire),
        .a     (rnd),
        .b     ({WIDTH{1'b0}}),
        .q     (w_s0)
    );

    assign out_s0    = w_s0;
    assign out_s1    = w_s1;
    assign enc_count = r_count;

`ifdef SHARE_CHECK_EN
    logic [WIDTH-1:0] r_ref;
    logic             r_chk_err;

    // Unmasked reference copy: verification aid only, it defeats the masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref     <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_ref <= in_data;
            end else if (w_out_fire) begin
                r_ref <= '0;
            end
            if ((r_state == c_ST_OUT) && ((w_s0 ^ w_s1) != r_ref)) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`endif

endmodule

`default_nettype wire
